// File: rtl/sobel_line_buffer_pkg.sv
// sobel_pkg: shared types and helpers for the Sobel line-buffer stage.
//   pixel_t    - one pixel at the default 24-bit depth
//   lb_state_e - line-buffer frame-tracking state
//   COL_W/ROW_W - counter widths for a given line width / frame height
package sobel_pkg;

    localparam int DATA_WIDTH = 24;

    typedef logic [DATA_WIDTH-1:0] pixel_t;

    typedef enum logic {
        LB_IDLE   = 1'b0,
        LB_ACTIVE = 1'b1
    } lb_state_e;

    function automatic int COL_W(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int ROW_W(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_buffer_if.sv
// sobel_line_buffer_if: pixel stream in, aligned column of three pixels out.
//   in_valid/in_ready/in_sof/in_data - raster pixel stream with handshake
//   stall                            - downstream busy, blocks acceptance
//   row0/row1/row2, shift_en         - window shift column and strobe
//   win_valid, sof_err               - window-complete flag, mid-frame SOF
// master: the pixel source / window side; slave: the line buffer.
interface sobel_line_buffer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sof;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  stall;
    logic [DATA_WIDTH-1:0] row0;
    logic [DATA_WIDTH-1:0] row1;
    logic [DATA_WIDTH-1:0] row2;
    logic                  shift_en;
    logic                  win_valid;
    logic                  sof_err;

    modport master (
        output in_valid, in_sof, in_data, stall,
        input  in_ready, row0, row1, row2, shift_en, win_valid, sof_err
    );

    modport slave (
        input  in_valid, in_sof, in_data, stall,
        output in_ready, row0, row1, row2, shift_en, win_valid, sof_err
    );
endinterface

// File: rtl/sobel_line_buffer_line_mem.sv
// sobel_line_mem: one image line of pixel storage, DEPTH entries.
//   clk     - clock
//   we_i    - write enable
//   addr_i  - shared read/write address
//   wdata_i - write data
//   rdata_o - read data; returns the value held before this cycle's write
// Contents are deliberately not reset.
module sobel_line_mem #(
    parameter int DEPTH      = 100,
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_W     = 7
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Asynchronous read: the write lands at the edge, so this is read-old.
    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two-line buffer feeding a 3x3 Sobel window.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of sobel_line_buffer_if (stream in, column out)
//   frame_done - only with LB_FRAME_DONE_EN defined: pulses with the
//                shift_en of the last pixel of a frame
//
// state     | meaning
// LB_IDLE   | waiting for in_sof; other pixels are consumed and dropped
// LB_ACTIVE | inside a frame; every accepted pixel is processed
module sobel_line_buffer #(
    parameter int WIDTH      = 100,
    parameter int HEIGHT     = 100,
    parameter int DATA_WIDTH = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    sobel_line_buffer_if.slave  bus
`ifdef LB_FRAME_DONE_EN
    ,
    output logic                frame_done
`endif
);
    import sobel_pkg::*;

    localparam int CW = COL_W(WIDTH);
    localparam int RW = ROW_W(HEIGHT);

    lb_state_e             state_q, state_d;
    logic [CW-1:0]         col_q, col_d, eff_col;
    logic [RW-1:0]         row_q, row_d, eff_row;
    logic [DATA_WIDTH-1:0] row0_q, row0_d, row1_q, row1_d, row2_q, row2_d;
    logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
    logic                  shift_q, shift_d, win_q, win_d, sof_err_q, sof_err_d;
    logic                  accept, process, last_px;

    assign bus.in_ready = ~bus.stall;
    assign accept       = bus.in_valid & ~bus.stall;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        row0_d    = row0_q;
        row1_d    = row1_q;
        row2_d    = row2_q;
        shift_d   = 1'b0;
        win_d     = 1'b0;
        sof_err_d = 1'b0;
        process   = 1'b0;
        last_px   = 1'b0;
        // An SOF pixel always starts a frame at (0,0), including a resync.
        eff_col   = bus.in_sof ? '0 : col_q;
        eff_row   = bus.in_sof ? '0 : row_q;

        unique case (state_q)
            LB_IDLE: begin
                process = accept & bus.in_sof;
            end
            LB_ACTIVE: begin
                process   = accept;
                sof_err_d = accept & bus.in_sof;
            end
            default: ;
        endcase

        if (process) begin
            last_px = (eff_col == CW'(WIDTH - 1)) && (eff_row == RW'(HEIGHT - 1));
            shift_d = 1'b1;
            win_d   = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
            row2_d  = bus.in_data;
            row1_d  = lb1_rd;
            row0_d  = lb0_rd;
            if (last_px) begin
                col_d   = '0;
                row_d   = '0;
                state_d = LB_IDLE;
            end else begin
                state_d = LB_ACTIVE;
                if (eff_col == CW'(WIDTH - 1)) begin
                    col_d = '0;
                    row_d = eff_row + 1'b1;
                end else begin
                    col_d = eff_col + 1'b1;
                    row_d = eff_row;
                end
            end
        end
    end

    // lb1 holds the previous line, lb0 the one before; a write shifts the
    // column up by one line.
    sobel_line_mem #(.DEPTH(WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_W(CW)) u_lb0 (
        .clk     (clk),
        .we_i    (process),
        .addr_i  (eff_col),
        .wdata_i (lb1_rd),
        .rdata_o (lb0_rd)
    );

    sobel_line_mem #(.DEPTH(WIDTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_W(CW)) u_lb1 (
        .clk     (clk),
        .we_i    (process),
        .addr_i  (eff_col),
        .wdata_i (bus.in_data),
        .rdata_o (lb1_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LB_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            row0_q    <= '0;
            row1_q    <= '0;
            row2_q    <= '0;
            shift_q   <= 1'b0;
            win_q     <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            row0_q    <= row0_d;
            row1_q    <= row1_d;
            row2_q    <= row2_d;
            shift_q   <= shift_d;
            win_q     <= win_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign bus.row0      = row0_q;
    assign bus.row1      = row1_q;
    assign bus.row2      = row2_q;
    assign bus.shift_en  = shift_q;
    assign bus.win_valid = win_q;
    assign bus.sof_err   = sof_err_q;

`ifdef LB_FRAME_DONE_EN
    logic frame_done_q;

    // A resync pixel is processed at (0,0), so last_px already excludes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= process & last_px;
        end
    end

    assign frame_done = frame_done_q;
`endif
endmodule

// File: tb/tb_sobel_line_buffer.sv
`timescale 1ns/1ps
module tb_sobel_line_buffer;
    import sobel_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_line_buffer_if #(.DATA_WIDTH(DW)) bus();
`ifdef LB_FRAME_DONE_EN
    logic frame_done;
`endif

    sobel_line_buffer #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef LB_FRAME_DONE_EN
        ,
        .frame_done (frame_done)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Downstream 3x3 window: win[r][0] takes the newest column.
    logic [DW-1:0] win [0:2][0:2];
    always @(posedge clk) begin
        if (bus.shift_en === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                win[i][2] <= win[i][1];
                win[i][1] <= win[i][0];
            end
            win[0][0] <= bus.row0;
            win[1][0] <= bus.row1;
            win[2][0] <= bus.row2;
        end
    end

    // Reference model: frame position as a pixel index, and per column the
    // last two pixels ever written there (the lines above, possibly stale).
    bit            m_active;
    int            m_k;
    logic [DW-1:0] h_last [W];
    logic [DW-1:0] h_prev [W];
    int            h_cnt  [W];
    logic [DW-1:0] e_r0, e_r1, e_r2;
    bit            e_k0, e_k1;
    bit            e_shift, e_win, e_serr, e_fd;

    task automatic model_reset();
        m_active = 0; m_k = 0;
        e_r0 = '0; e_r1 = '0; e_r2 = '0; e_k0 = 1; e_k1 = 1;
        e_shift = 0; e_win = 0; e_serr = 0; e_fd = 0;
    endtask

    task automatic drive_cycle(input bit v, input bit sof, input logic [DW-1:0] d, input bit st);
        bit acc;
        int c, r;
        bus.in_valid = v; bus.in_sof = sof; bus.in_data = d; bus.stall = st;
        acc = v && !st;
        e_shift = 0; e_win = 0; e_serr = 0; e_fd = 0;
        if (acc && sof) begin
            e_serr   = m_active;
            m_active = 1;
            m_k      = 0;
        end
        if (acc && m_active) begin
            c = m_k % W;
            r = m_k / W;
            e_shift = 1;
            e_win   = (r >= 2) && (c >= 2);
            e_fd    = (m_k == W*H - 1);
            e_r2 = d;
            e_k1 = h_cnt[c] >= 1; e_r1 = h_last[c];
            e_k0 = h_cnt[c] >= 2; e_r0 = h_prev[c];
            h_prev[c] = h_last[c];
            h_last[c] = d;
            if (h_cnt[c] < 2) h_cnt[c]++;
            if (m_k == W*H - 1) begin m_active = 0; m_k = 0; end
            else m_k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 0; bus.in_sof = 0; bus.in_data = '0; bus.stall = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.shift_en !== 1'b0 || bus.win_valid !== 1'b0 || bus.sof_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: in_ready=%b shift_en=%b win_valid=%b sof_err=%b, want 1 0 0 0",
                     bus.in_ready, bus.shift_en, bus.win_valid, bus.sof_err);
        end
        checks++;
        if (bus.row0 !== '0 || bus.row1 !== '0 || bus.row2 !== '0) begin
            errors++;
            $display("FAIL reset_rows: rows=%0d/%0d/%0d, want 0/0/0", bus.row0, bus.row1, bus.row2);
        end
`ifdef LB_FRAME_DONE_EN
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_done: got %b want 0", frame_done);
        end
`endif
    endtask

    task automatic test_full_frame(input string tag);
        int nshift = 0, nwin = 0, nfd = 0;
        bit want_win;
        for (int p = 1; p <= W*H; p++) begin
            drive_cycle(1, p == 1, DW'(p), 0);
            want_win = (p == 11) || (p == 12) || (p == 15) || (p == 16);
            checks++;
            if (bus.shift_en !== 1'b1 || bus.win_valid !== want_win || bus.row2 !== DW'(p) || bus.sof_err !== 1'b0) begin
                errors++;
                $display("FAIL %s px%0d: shift_en=%b win_valid=%b row2=%0d sof_err=%b, want 1 %b %0d 0",
                         tag, p, bus.shift_en, bus.win_valid, bus.row2, bus.sof_err, want_win, p);
            end
            if (bus.shift_en === 1'b1) nshift++;
            if (bus.win_valid === 1'b1) nwin++;
`ifdef LB_FRAME_DONE_EN
            if (frame_done === 1'b1) nfd++;
            checks++;
            if (frame_done !== (p == W*H)) begin
                errors++;
                $display("FAIL %s frame_done px%0d: got %b want %b", tag, p, frame_done, p == W*H);
            end
`endif
            if (p == 11) begin
                checks++;
                if (bus.row2 !== DW'(11) || bus.row1 !== DW'(7) || bus.row0 !== DW'(3)) begin
                    errors++;
                    $display("FAIL %s px11_rows: %0d/%0d/%0d, want 3/7/11", tag, bus.row0, bus.row1, bus.row2);
                end
            end
            if (p == 12) begin
                checks++;
                if (win[0][0] !== DW'(3)  || win[0][1] !== DW'(2)  || win[0][2] !== DW'(1) ||
                    win[1][0] !== DW'(7)  || win[1][1] !== DW'(6)  || win[1][2] !== DW'(5) ||
                    win[2][0] !== DW'(11) || win[2][1] !== DW'(10) || win[2][2] !== DW'(9)) begin
                    errors++;
                    $display("FAIL %s window: %0d,%0d,%0d/%0d,%0d,%0d/%0d,%0d,%0d, want 3,2,1/7,6,5/11,10,9", tag,
                             win[0][0], win[0][1], win[0][2], win[1][0], win[1][1], win[1][2],
                             win[2][0], win[2][1], win[2][2]);
                end
            end
        end
        drive_cycle(0, 0, '0, 0);
        checks++;
        if (nshift != W*H || nwin != (W-2)*(H-2) || bus.shift_en !== 1'b0) begin
            errors++;
            $display("FAIL %s counts: shifts=%0d wins=%0d trailing_shift=%b, want %0d %0d 0",
                     tag, nshift, nwin, bus.shift_en, W*H, (W-2)*(H-2));
        end
`ifdef LB_FRAME_DONE_EN
        checks++;
        if (nfd != 1) begin
            errors++;
            $display("FAIL %s frame_done_count: got %0d want 1", tag, nfd);
        end
`endif
    endtask

    task automatic test_drop_idle();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            drive_cycle(1, 0, DW'(100 + p), 0);
            checks++;
            if (bus.shift_en !== 1'b0 || bus.row2 !== '0) begin
                errors++;
                $display("FAIL drop_idle px%0d: shift_en=%b row2=%0d, want 0 0", p, bus.shift_en, bus.row2);
            end
        end
        test_full_frame("after_drop");
    endtask

    task automatic test_stall();
        for (int p = 1; p <= 5; p++) drive_cycle(1, p == 1, DW'(p), 0);
        for (int s = 0; s < 3; s++) begin
            bus.in_valid = 1; bus.stall = 1; bus.in_data = DW'(99);
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready cyc%0d: in_ready=%b want 0", s, bus.in_ready);
            end
            drive_cycle(1, 0, DW'(99), 1);
            checks++;
            if (bus.shift_en !== 1'b0 || bus.row2 !== DW'(5) || bus.row1 !== DW'(1) || (e_k0 && bus.row0 !== e_r0)) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: shift_en=%b row2=%0d row1=%0d, want 0 5 1", s, bus.shift_en, bus.row2, bus.row1);
            end
        end
        for (int p = 6; p <= W*H; p++) begin
            drive_cycle(1, 0, DW'(p), 0);
            checks++;
            if (bus.shift_en !== 1'b1 || bus.row2 !== DW'(p) || bus.win_valid !== e_win) begin
                errors++;
                $display("FAIL stall_resume px%0d: shift_en=%b row2=%0d win_valid=%b, want 1 %0d %b",
                         p, bus.shift_en, bus.row2, bus.win_valid, p, e_win);
            end
        end
        drive_cycle(0, 0, '0, 0);
    endtask

    task automatic test_resync();
        int nerr = 0, first_win = 0;
        for (int p = 1; p <= 5 + W*H; p++) begin
            drive_cycle(1, (p == 1) || (p == 6), DW'(p), 0);
            if (bus.sof_err === 1'b1) nerr++;
            if (bus.win_valid === 1'b1 && first_win == 0) first_win = p;
            checks++;
            if (bus.sof_err !== (p == 6) || bus.shift_en !== 1'b1) begin
                errors++;
                $display("FAIL resync px%0d: sof_err=%b shift_en=%b, want %b 1", p, bus.sof_err, bus.shift_en, p == 6);
            end
        end
        drive_cycle(0, 0, '0, 0);
        checks++;
        if (nerr != 1 || first_win != 6 + 10) begin
            errors++;
            $display("FAIL resync_summary: sof_err pulses=%0d first win px=%0d, want 1 16", nerr, first_win);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int p = 1; p <= 8; p++) drive_cycle(1, p == 1, DW'(p), 0);
        bus.in_valid = 1; bus.in_sof = 0; bus.in_data = DW'(9); bus.stall = 0;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (bus.shift_en !== 1'b0 || bus.row0 !== '0 || bus.row1 !== '0 || bus.row2 !== '0 || bus.win_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: shift_en=%b rows=%0d/%0d/%0d win_valid=%b, want all 0",
                     bus.shift_en, bus.row0, bus.row1, bus.row2, bus.win_valid);
        end
        repeat (2) @(posedge clk);
        #2;
        bus.in_valid = 0; bus.in_data = '0;
        rst_n = 1;
        @(posedge clk);
        #1;
        test_full_frame("after_mid_reset");
    endtask

    task automatic test_random();
        bit v, sof, st, bad;
        logic [DW-1:0] d;
        for (int n = 0; n < 400; n++) begin
            v   = $urandom_range(0, 9) < 7;
            st  = $urandom_range(0, 9) < 2;
            sof = m_active ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0);
            d   = DW'($urandom);
            drive_cycle(v, sof, d, st);
            bad = bus.shift_en !== e_shift || bus.win_valid !== e_win || bus.sof_err !== e_serr ||
                  bus.row2 !== e_r2 || (e_k1 && bus.row1 !== e_r1) || (e_k0 && bus.row0 !== e_r0);
`ifdef LB_FRAME_DONE_EN
            bad = bad || (frame_done !== e_fd);
`endif
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL random cyc%0d: shift/win/serr=%b%b%b rows=%h/%h/%h, want %b%b%b %h(%b)/%h(%b)/%h",
                         n, bus.shift_en, bus.win_valid, bus.sof_err, bus.row0, bus.row1, bus.row2,
                         e_shift, e_win, e_serr, e_r0, e_k0, e_r1, e_k1, e_r2);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < W; c++) begin
            h_cnt[c] = 0; h_last[c] = '0; h_prev[c] = '0;
        end
        test_reset();
        test_full_frame("full_frame");
        test_drop_idle();
        test_stall();
        test_resync();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sobel_line_buffer.md
Name: sobel_line_buffer

Overview:
Line-buffer stage that sits directly upstream of the 3x3 pixel window register in the Sobel accelerator. Accepts a raster-order pixel stream with valid/ready handshake and stores the two previous image lines. Emits three vertically aligned pixels, row0/row1/row2, plus shift_en, which drive the window's shift inputs. Tracks column and row position and flags when the downstream window holds a complete 3x3 neighbourhood.

Parameters:
WIDTH, 100, pixels per image line (>=3)
HEIGHT, 100, lines per frame (>=3)
DATA_WIDTH, 24, bits per pixel

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept pixel; combinational = !stall
in_sof  in  1  marks first pixel of frame (qualified by in_valid)
in_data  in  DATA_WIDTH  input pixel
stall  in  1  downstream busy; blocks acceptance
row0  out  DATA_WIDTH  pixel two lines above current, same column
row1  out  DATA_WIDTH  pixel one line above current, same column
row2  out  DATA_WIDTH  current pixel
shift_en  out  1  one-cycle strobe: row0..2 valid, shift window
win_valid  out  1  with shift_en: window complete after this shift
sof_err  out  1  one-cycle pulse: in_sof received mid-frame

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Accept = in_valid & in_ready. in_ready = !stall; no other backpressure.
- Two line memories lb0, lb1, WIDTH x DATA_WIDTH each, as register arrays. Contents are not reset or cleared; win_valid gating keeps stale data out of use.
- On accept at column col:
  - row2 <= in_data
  - row1 <= lb1[col]
  - row0 <= lb0[col]
  - lb0[col] <= lb1[col]
  - lb1[col] <= in_data
  - All reads return pre-write (old) values.
- Latency: outputs registered, one cycle after accept. shift_en = registered accept; low on cycles with no accept. row0..2 hold their values when shift_en = 0.
- Counters: col, width $clog2(WIDTH); row, width $clog2(HEIGHT). col wraps at WIDTH-1 to 0 and increments row at the wrap.
- win_valid = registered (accept & row>=2 & col>=2), evaluated on the counters of the accepted pixel. The downstream window holds the full neighbourhood one cycle after win_valid. Per frame: exactly (WIDTH-2)*(HEIGHT-2) win_valid pulses.
- FSM states IDLE and ACTIVE; reset to IDLE.
  - IDLE: accepted pixel with in_sof=1 is processed as col=0, row=0 and moves to ACTIVE. Accepted pixel with in_sof=0 is consumed and dropped: no shift_en, no memory write.
  - ACTIVE: every accepted pixel is processed. Pixel at col=WIDTH-1, row=HEIGHT-1 is processed, counters return to 0, FSM returns to IDLE.
  - ACTIVE with in_sof=1 accepted: sof_err pulses next cycle. The pixel is processed as col=0, row=0 of a new frame; FSM stays ACTIVE.
- Last pixel of frame with in_sof=1: treated as resync as above; sof_err pulses.
- Reset values: row0..2=0, shift_en=0, win_valid=0, sof_err=0, col=0, row=0, FSM=IDLE.
- Reset mid-frame: all of the above apply immediately; line memories keep stale data.

Optional Feature:
- Macro: LB_FRAME_DONE_EN.
- Defined: adds output port frame_done (1 bit, reset 0). It pulses high in the same cycle as the shift_en of pixel (WIDTH-1, HEIGHT-1), and is not asserted on a resync.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package sobel_pkg:
  - pixel_t (logic [DATA_WIDTH-1:0]) with default DATA_WIDTH=24
  - lb_state_e enum {LB_IDLE, LB_ACTIVE}
  - COL_W/ROW_W helper functions based on $clog2
- One sub-module, sobel_line_mem: single-line WIDTH-deep memory, one read and one write per cycle at the same address, read-old semantics. Instantiated twice (lb0, lb1).

Test Plan:
- Reset: WIDTH=4, HEIGHT=4; release rst_n, no input -> all outputs 0, in_ready=1.
- Full frame, WIDTH=4, HEIGHT=4, pixels 1..16 with in_sof on pixel 1, no stall -> 16 shift_en pulses.
  - win_valid only for pixels 11, 12, 15, 16 (4 pulses).
  - At pixel 11: row2=11, row1=7, row0=3.
  - With the window instantiated downstream, one cycle after pixel 11's shift_en: p11..p33 = 3,2,1 / 7,6,5 / 11,10,9.
- Stall: assert stall for 3 cycles mid-line with in_valid=1 -> in_ready=0, no shift_en, outputs held; resumes with the next pixel value and no loss.
- Drop in IDLE: 5 valid pixels without in_sof after reset -> no shift_en. A following frame with in_sof produces the same results as the full-frame test.
- Resync: in_sof on pixel 6 of the frame -> sof_err pulses once; the pixel is processed as col 0 / row 0. win_valid first appears on the 11th pixel counted from the resync.
- Reset mid-frame at pixel 9, then a full frame -> identical to the full-frame test. With LB_FRAME_DONE_EN, frame_done pulses once, aligned with pixel 16's shift_en.
